add_num_operand_fetch: RTL and testbench
========================================

ADD_NUM_OPERAND_FETCH -- requirements
Module: add_num_operand_fetch

Interface
REQ-001 Parameter ADDR_W, default 42, width of cache-line address.
REQ-002 Parameter TAG_W, default 16, width of read-request mdata tag.
REQ-003 Parameter OPA_LSB, default 8, bit offset of operand A within the returned line.
REQ-004 Parameter OPB_LSB, default 16, bit offset of operand B within the returned line.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, response wait limit, used only when timeout is compiled in.
REQ-006 clk  in  1  clock, all logic on rising edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 start_valid  in  1  one-cycle pulse requesting one operand fetch.
REQ-009 start_addr  in  ADDR_W  cache-line address to read, sampled with start_valid.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 rd_req_valid  out  1  c0 read request valid, single-cycle pulse.
REQ-012 rd_req_addr  out  ADDR_W  read request address.
REQ-013 rd_req_mdata  out  TAG_W  read request tag.
REQ-014 rd_almfull  in  1  c0 TX almost-full; no request issued while high.
REQ-015 rd_rsp_valid  in  1  c0 read response valid.
REQ-016 rd_rsp_mdata  in  TAG_W  tag of the response.
REQ-017 rd_rsp_data  in  512  returned cache line.
REQ-018 op_valid  out  1  operand pair valid toward the add/write stage.
REQ-019 op_ready  in  1  downstream accepts operands when op_valid and op_ready both high.
REQ-020 op_a  out  8  operand A.
REQ-021 op_b  out  8  operand B.
REQ-022 err_timeout  out  1  one-cycle pulse on response timeout.

Function
REQ-023 States: IDLE, REQ, WAIT, OUT (plus timeout path to IDLE).
REQ-024 IDLE: start_valid -> latch start_addr, go REQ next cycle; start_valid in any other state ignored, no side effect.
REQ-025 REQ: if rd_almfull low -> rd_req_valid high for exactly one cycle with latched address and current tag, go WAIT; if high -> stay REQ, rd_req_valid low.
REQ-026 Tag counter increments by 1 after each issued request, wraps from 2^TAG_W-1 to 0.
REQ-027 WAIT: rd_rsp_valid with rd_rsp_mdata equal to issued tag -> capture op_a = rd_rsp_data[OPA_LSB+7:OPA_LSB], op_b = rd_rsp_data[OPB_LSB+7:OPB_LSB], go OUT; mismatched-tag responses ignored.
REQ-028 Response-to-op_valid latency: exactly 1 cycle (op_valid high the cycle after accepted response).
REQ-029 OUT: op_valid high, op_a/op_b stable until handshake; op_valid and op_ready -> IDLE next cycle, op_valid low.
REQ-030 Response arriving in the same cycle as a start_valid in WAIT: response handled, start ignored.
REQ-031 rd_rsp_valid in IDLE, REQ, or OUT ignored.

Reset
REQ-032 reset_n low at a clock edge -> state IDLE, rd_req_valid 0, op_valid 0, err_timeout 0, tag 0, op_a 0, op_b 0, latched address 0.
REQ-033 Reset mid-operation aborts the fetch; a later response for the aborted tag is ignored.

Configuration
REQ-034 Macro ADD_NUM_FETCH_TIMEOUT_EN defined: WAIT counts cycles from entry; reaching TIMEOUT_CYCLES without matching response -> err_timeout pulse 1 cycle, go IDLE, op_valid never asserted for that fetch.
REQ-035 Macro not defined: no counter, WAIT lasts indefinitely, err_timeout tied 0.

Verification
REQ-036 Reset, start_valid with addr 0x100, rd_almfull 0 -> rd_req_valid 1 cycle with addr 0x100, mdata 0; response mdata 0, data[15:8]=0x12, data[23:16]=0x34 -> next cycle op_valid, op_a 0x12, op_b 0x34.
REQ-037 rd_almfull held high 5 cycles after start -> no rd_req_valid for those 5 cycles, request issued the cycle almfull drops.
REQ-038 Response with mdata 7 while waiting for tag 0, then tag 0 -> first ignored, operands from second only.
REQ-039 op_ready low 10 cycles in OUT -> op_valid, op_a, op_b held constant; second start_valid during that time produces no request.
REQ-040 With ADD_NUM_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES 16, no response -> err_timeout pulse 16 cycles after WAIT entry, busy low next cycle; new start then issues mdata 1.
REQ-041 reset_n low during WAIT, then late response with old tag -> no op_valid, state IDLE, next request uses mdata 0.

Source files
------------

// File: rtl/add_num_operand_fetch.sv
// rtl/add_num_operand_fetch.sv - issue one tagged cache-line read, return operands A/B.
// Optional response timeout compiled in with `define ADD_NUM_FETCH_TIMEOUT_EN.
module add_num_operand_fetch #(
  parameter int ADDR_W         = 42,
  parameter int TAG_W          = 16,
  parameter int OPA_LSB        = 8,
  parameter int OPB_LSB        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_valid,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [TAG_W-1:0]  rd_req_mdata,
  input  logic              rd_almfull,
  input  logic              rd_rsp_valid,
  input  logic [TAG_W-1:0]  rd_rsp_mdata,
  input  logic [511:0]      rd_rsp_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [7:0]        op_a,
  output logic [7:0]        op_b,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TAG_W-1:0]    issued_tag_q, issued_tag_d;
  logic [7:0]          op_a_q, op_a_d;
  logic [7:0]          op_b_q, op_b_d;
  logic                rsp_match;
  logic                timeout_hit;
  logic                err_timeout_c;

  // Only the two operand bytes of the line are consumed.
  logic unused_bits;
  assign unused_bits = ^{rd_rsp_data, (TIMEOUT_CYCLES == 0)};

  assign rsp_match = rd_rsp_valid && (rd_rsp_mdata == issued_tag_q);

`ifdef ADD_NUM_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on the first WAIT cycle and advances once per WAIT cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    tag_d         = tag_q;
    issued_tag_d  = issued_tag_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    rd_req_valid  = 1'b0;
    op_valid      = 1'b0;
    err_timeout_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          addr_d  = start_addr;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!rd_almfull) begin
          rd_req_valid = 1'b1;
          issued_tag_d = tag_q;
          tag_d        = tag_q + TAG_W'(1);
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // A matching response in the timeout cycle still wins.
        if (rsp_match) begin
          op_a_d  = rd_rsp_data[OPA_LSB +: 8];
          op_b_d  = rd_rsp_data[OPB_LSB +: 8];
          state_d = S_OUT;
        end else if (timeout_hit) begin
          err_timeout_c = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_OUT: begin
        op_valid = 1'b1;
        if (op_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tag_q        <= '0;
      issued_tag_q <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
      issued_tag_q <= issued_tag_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign rd_req_addr  = addr_q;
  assign rd_req_mdata = tag_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign err_timeout  = err_timeout_c;

endmodule

// File: tb/tb_add_num_operand_fetch.sv
// tb/tb_add_num_operand_fetch.sv - randomized self-checking bench for add_num_operand_fetch.
`timescale 1ns/1ps
module tb_add_num_operand_fetch;

  localparam int ADDR_W  = 42;
  localparam int TAG_W   = 4;
  localparam int OPA_LSB = 8;
  localparam int OPB_LSB = 16;
  localparam int TMO     = 16;
  localparam int NTAGS   = 1 << TAG_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start_valid = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              busy;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [TAG_W-1:0]  rd_req_mdata;
  logic              rd_almfull = 1'b0;
  logic              rd_rsp_valid = 1'b0;
  logic [TAG_W-1:0]  rd_rsp_mdata = '0;
  logic [511:0]      rd_rsp_data = '0;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic [7:0]        op_a;
  logic [7:0]        op_b;
  logic              err_timeout;

  int errors = 0;
  int checks = 0;
  int model_tag = 0;

  always #5 clk = ~clk;

  add_num_operand_fetch #(
    .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OPA_LSB(OPA_LSB), .OPB_LSB(OPB_LSB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_addr(start_addr),
    .busy(busy), .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_mdata(rd_req_mdata), .rd_almfull(rd_almfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data), .op_valid(op_valid),
    .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .err_timeout(err_timeout)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [7:0] field(input logic [511:0] line, input int lsb);
    return 8'(line >> lsb);
  endfunction

  function automatic logic [ADDR_W-1:0] rand_addr();
    return ADDR_W'({$urandom(), $urandom()});
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    #1;
    checks++;
    if ({busy, rd_req_valid, op_valid, err_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {busy, rd_req_valid, op_valid, err_timeout});
    end
    checks++;
    if ({op_a, op_b, rd_req_mdata, rd_req_addr} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got a=%h b=%h tag=%h addr=%h want all 0", op_a, op_b, rd_req_mdata, rd_req_addr);
    end
    reset_n = 1'b1;
    model_tag = 0;
    cyc();
  endtask

  task automatic test_basic();
    logic [511:0] line;
    start_valid = 1'b1;
    start_addr  = ADDR_W'(42'h100);
    cyc();
    start_valid = 1'b0;
    #1;
    checks++;
    if ({rd_req_valid, busy, rd_req_addr, rd_req_mdata} !== {1'b1, 1'b1, ADDR_W'(42'h100), TAG_W'(0)}) begin
      errors++;
      $display("FAIL basic_req: got v=%b busy=%b addr=%h tag=%h want v=1 busy=1 addr=100 tag=0",
               rd_req_valid, busy, rd_req_addr, rd_req_mdata);
    end
    cyc();
    model_tag = (model_tag + 1) % NTAGS;
    checks++;
    if (rd_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_req_pulse: got %b want 0", rd_req_valid);
    end
    line = '0;
    line[15:8]  = 8'h12;
    line[23:16] = 8'h34;
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = '0;
    rd_rsp_data  = line;
    #1;
    checks++;
    if (op_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got op_valid=%b want 0", op_valid);
    end
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL basic_ops: got v=%b a=%h b=%h want v=1 a=12 b=34", op_valid, op_a, op_b);
    end
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    #1;
    checks++;
    if ({op_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done: got v=%b busy=%b want 0 0", op_valid, busy);
    end
  endtask

  task automatic test_almfull();
    logic [511:0]      line;
    logic [ADDR_W-1:0] addr;
    addr = rand_addr();
    line = rand_line();
    rd_almfull  = 1'b1;
    start_valid = 1'b1;
    start_addr  = addr;
    cyc();
    start_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({rd_req_valid, busy} !== 2'b01) begin
        errors++;
        $display("FAIL almfull_hold[%0d]: got v=%b busy=%b want v=0 busy=1", i, rd_req_valid, busy);
      end
      cyc();
    end
    rd_almfull = 1'b0;
    #1;
    checks++;
    if ({rd_req_valid, rd_req_addr, rd_req_mdata} !== {1'b1, addr, TAG_W'(model_tag)}) begin
      errors++;
      $display("FAIL almfull_issue: got v=%b addr=%h tag=%h want v=1 addr=%h tag=%h",
               rd_req_valid, rd_req_addr, rd_req_mdata, addr, TAG_W'(model_tag));
    end
    cyc();
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(model_tag);
    rd_rsp_data  = line;
    model_tag = (model_tag + 1) % NTAGS;
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, field(line, OPA_LSB), field(line, OPB_LSB)}) begin
      errors++;
      $display("FAIL almfull_ops: got v=%b a=%h b=%h want v=1 a=%h b=%h",
               op_valid, op_a, op_b, field(line, OPA_LSB), field(line, OPB_LSB));
    end
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
  endtask

  task automatic test_tag_filter();
    logic [511:0] bad, good;
    int t;
    bad  = rand_line();
    good = rand_line();
    t = model_tag;
    start_valid = 1'b1;
    start_addr  = rand_addr();
    cyc();
    start_valid = 1'b0;
    cyc();
    model_tag = (model_tag + 1) % NTAGS;
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(t ^ 7);
    rd_rsp_data  = bad;
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({op_valid, busy} !== 2'b01) begin
      errors++;
      $display("FAIL filter_ignore: got v=%b busy=%b want v=0 busy=1", op_valid, busy);
    end
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(t);
    rd_rsp_data  = good;
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, field(good, OPA_LSB), field(good, OPB_LSB)}) begin
      errors++;
      $display("FAIL filter_ops: got v=%b a=%h b=%h want v=1 a=%h b=%h",
               op_valid, op_a, op_b, field(good, OPA_LSB), field(good, OPB_LSB));
    end
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
  endtask

  task automatic test_hold();
    logic [511:0] line;
    int t;
    line = rand_line();
    t = model_tag;
    start_valid = 1'b1;
    start_addr  = rand_addr();
    cyc();
    start_valid = 1'b0;
    cyc();
    model_tag = (model_tag + 1) % NTAGS;
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(t);
    rd_rsp_data  = line;
    cyc();
    // Stray responses and a second start while stalled must change nothing.
    for (int i = 0; i < 10; i++) begin
      start_valid  = (i == 3);
      start_addr   = rand_addr();
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = rand_line();
      #1;
      checks++;
      if ({op_valid, rd_req_valid, op_a, op_b} !== {2'b10, field(line, OPA_LSB), field(line, OPB_LSB)}) begin
        errors++;
        $display("FAIL hold[%0d]: got v=%b req=%b a=%h b=%h want v=1 req=0 a=%h b=%h",
                 i, op_valid, rd_req_valid, op_a, op_b, field(line, OPA_LSB), field(line, OPB_LSB));
      end
      cyc();
    end
    start_valid  = 1'b0;
    rd_rsp_valid = 1'b0;
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({busy, rd_req_valid, op_valid} !== 3'b000) begin
        errors++;
        $display("FAIL hold_after[%0d]: got busy=%b req=%b v=%b want 000", i, busy, rd_req_valid, op_valid);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [511:0]      line;
    logic [ADDR_W-1:0] addr;
    int t, nfull, nbad, ndelay;
    for (int it = 0; it < 24; it++) begin
      addr   = rand_addr();
      line   = rand_line();
      nfull  = $urandom_range(0, 3);
      nbad   = $urandom_range(0, 2);
      ndelay = $urandom_range(0, 3);
      t = model_tag;
      rd_almfull  = (nfull != 0);
      start_valid = 1'b1;
      start_addr  = addr;
      cyc();
      start_valid = 1'b0;
      for (int i = 0; i < nfull; i++) begin
        #1;
        checks++;
        if (rd_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_almfull[%0d]: got req=%b want 0", it, rd_req_valid);
        end
        cyc();
      end
      rd_almfull = 1'b0;
      #1;
      checks++;
      if ({rd_req_valid, rd_req_addr, rd_req_mdata} !== {1'b1, addr, TAG_W'(t)}) begin
        errors++;
        $display("FAIL rand_req[%0d]: got v=%b addr=%h tag=%h want v=1 addr=%h tag=%h",
                 it, rd_req_valid, rd_req_addr, rd_req_mdata, addr, TAG_W'(t));
      end
      cyc();
      model_tag = (model_tag + 1) % NTAGS;
      for (int b = 0; b < nbad; b++) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = TAG_W'(t ^ $urandom_range(1, NTAGS - 1));
        rd_rsp_data  = rand_line();
        start_valid  = $urandom_range(0, 1);
        cyc();
        rd_rsp_valid = 1'b0;
        start_valid  = 1'b0;
        #1;
        checks++;
        if (op_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_bad_tag[%0d]: got v=%b want 0", it, op_valid);
        end
      end
      // Matching response coincides with a start pulse; the start is dropped.
      rd_rsp_valid = 1'b1;
      rd_rsp_mdata = TAG_W'(t);
      rd_rsp_data  = line;
      start_valid  = 1'b1;
      cyc();
      rd_rsp_valid = 1'b0;
      start_valid  = 1'b0;
      for (int d = 0; d <= ndelay; d++) begin
        op_ready = (d == ndelay);
        #1;
        checks++;
        if ({op_valid, op_a, op_b} !== {1'b1, field(line, OPA_LSB), field(line, OPB_LSB)}) begin
          errors++;
          $display("FAIL rand_ops[%0d]: got v=%b a=%h b=%h want v=1 a=%h b=%h",
                   it, op_valid, op_a, op_b, field(line, OPA_LSB), field(line, OPB_LSB));
        end
        cyc();
      end
      op_ready = 1'b0;
      #1;
      checks++;
      if ({busy, rd_req_valid, op_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rand_idle[%0d]: got busy=%b req=%b v=%b want 000", it, busy, rd_req_valid, op_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] line;
    int t;
    line = rand_line();
    t = model_tag;
    start_valid = 1'b1;
    start_addr  = rand_addr();
    cyc();
    start_valid = 1'b0;
    cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    model_tag = 0;
    #1;
    checks++;
    if ({busy, op_valid, rd_req_mdata} !== {2'b00, TAG_W'(0)}) begin
      errors++;
      $display("FAIL rstmid_state: got busy=%b v=%b tag=%h want 0 0 0", busy, op_valid, rd_req_mdata);
    end
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(t);
    rd_rsp_data  = line;
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({busy, op_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_late_rsp: got busy=%b v=%b want 0 0", busy, op_valid);
    end
    start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    #1;
    checks++;
    if ({rd_req_valid, rd_req_mdata} !== {1'b1, TAG_W'(model_tag)}) begin
      errors++;
      $display("FAIL rstmid_next_req: got v=%b tag=%h want v=1 tag=%h", rd_req_valid, rd_req_mdata, TAG_W'(model_tag));
    end
    cyc();
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(model_tag);
    model_tag = (model_tag + 1) % NTAGS;
    cyc();
    rd_rsp_valid = 1'b0;
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic [511:0] line;
    line = rand_line();
`ifdef ADD_NUM_FETCH_TIMEOUT_EN
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    model_tag = 0;
    start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    cyc();
    model_tag = (model_tag + 1) % NTAGS;
    for (int i = 0; i < TMO; i++) begin
      #1;
      checks++;
      if ({err_timeout, busy} !== 2'b01) begin
        errors++;
        $display("FAIL tmo_wait[%0d]: got err=%b busy=%b want 0 1", i, err_timeout, busy);
      end
      cyc();
    end
    #1;
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_pulse: got err=%b want 1", err_timeout);
    end
    cyc();
    checks++;
    if ({busy, err_timeout, op_valid} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_after: got busy=%b err=%b v=%b want 000", busy, err_timeout, op_valid);
    end
    start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    #1;
    checks++;
    if ({rd_req_valid, rd_req_mdata} !== {1'b1, TAG_W'(1)}) begin
      errors++;
      $display("FAIL tmo_next_tag: got v=%b tag=%h want v=1 tag=1", rd_req_valid, rd_req_mdata);
    end
    cyc();
`else
    start_valid = 1'b1;
    cyc();
    start_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3 * TMO; i++) begin
      #1;
      checks++;
      if ({err_timeout, busy, op_valid} !== 3'b010) begin
        errors++;
        $display("FAIL notmo_wait[%0d]: got err=%b busy=%b v=%b want 0 1 0", i, err_timeout, busy, op_valid);
      end
      cyc();
    end
`endif
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = TAG_W'(model_tag);
    rd_rsp_data  = line;
    model_tag = (model_tag + 1) % NTAGS;
    cyc();
    rd_rsp_valid = 1'b0;
    #1;
    checks++;
    if ({op_valid, op_a, op_b} !== {1'b1, field(line, OPA_LSB), field(line, OPB_LSB)}) begin
      errors++;
      $display("FAIL tmo_final_ops: got v=%b a=%h b=%h want v=1 a=%h b=%h",
               op_valid, op_a, op_b, field(line, OPA_LSB), field(line, OPB_LSB));
    end
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_almfull();
    test_tag_filter();
    test_hold();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
